// File: rtl/request_scheduler.sv
// request_scheduler: queued DRAM command scheduler with per-bank open-row tracking and ACT/PRE timers.
// Config macro SCHED_FRFCFS_EN: row hits are taken from anywhere in the queue (oldest first); default is head-only.
module request_scheduler #(
  parameter int BUS_WIDTH          = 16,
  parameter int BANK_GROUPS        = 2,
  parameter int BANKS_PER_GROUP    = 4,
  parameter int ROW_BITS           = 8,
  parameter int COL_BITS           = 4,
  parameter int PADDR_BITS         = 19,
  parameter int QUEUE_SIZE         = 16,
  parameter int ACTIVATION_LATENCY = 8,
  parameter int PRECHARGE_LATENCY  = 5,
  parameter int BANKS              = 8
) (
  input  logic                               clk_in,
  input  logic                               rst_in,
  input  logic [PADDR_BITS-1:0]              mem_bus_addr_in,
  input  logic                               valid_in,
  input  logic                               write_in,
  input  logic [511:0]                       val_in,
  input  logic                               cmd_ready,
  input  logic                               bursting,
  output logic [PADDR_BITS-1:0]              addr_out,
  output logic [$clog2(BANK_GROUPS)-1:0]     bank_group_out,
  output logic [$clog2(BANKS_PER_GROUP)-1:0] bank_out,
  output logic [ROW_BITS-1:0]                row_out,
  output logic [COL_BITS-1:0]                col_out,
  output logic [511:0]                       val_out,
  output logic [2:0]                         cmd_out,
  output logic                               valid_out
);

  localparam int BGW  = $clog2(BANK_GROUPS);
  localparam int BKW  = $clog2(BANKS_PER_GROUP);
  localparam int BIW  = BGW + BKW;
  localparam int OFF  = PADDR_BITS - ROW_BITS - COL_BITS - BIW;
  localparam int IW   = $clog2(QUEUE_SIZE);
  localparam int CW   = $clog2(QUEUE_SIZE + 1);
  localparam int TMAX = (ACTIVATION_LATENCY > PRECHARGE_LATENCY) ? ACTIVATION_LATENCY : PRECHARGE_LATENCY;
  localparam int TW   = $clog2(TMAX + 1);

`ifdef SCHED_FRFCFS_EN
  localparam int SCAN = QUEUE_SIZE;
`else
  localparam int SCAN = 1;
`endif

  if (BANKS != BANK_GROUPS * BANKS_PER_GROUP) begin : g_bad_banks
    $error("BANKS must equal BANK_GROUPS*BANKS_PER_GROUP");
  end
  if (BUS_WIDTH < 1) begin : g_bad_bus
    $error("BUS_WIDTH must be positive");
  end

  typedef enum logic [2:0] {
    CMD_NOP = 3'd0,
    CMD_ACT = 3'd1,
    CMD_RD  = 3'd2,
    CMD_WR  = 3'd3,
    CMD_PRE = 3'd4
  } cmd_e;

  logic [PADDR_BITS-1:0]  r_q_addr [QUEUE_SIZE];
  logic                   r_q_wr   [QUEUE_SIZE];
  logic [511:0]           r_q_val  [QUEUE_SIZE];
  logic [CW-1:0]          r_count;

  logic                   r_open [BANKS];
  logic [ROW_BITS-1:0]    r_row  [BANKS];
  logic [TW-1:0]          r_tmr  [BANKS];

  logic [PADDR_BITS-1:0]  r_addr_out;
  logic [BGW-1:0]         r_bg_out;
  logic [BKW-1:0]         r_bank_out;
  logic [ROW_BITS-1:0]    r_row_out;
  logic [COL_BITS-1:0]    r_col_out;
  logic [511:0]           r_val_out;
  logic [2:0]             r_cmd_out;
  logic                   r_valid_out;

  logic                   w_hit;
  logic [IW-1:0]          w_hit_idx;
  logic [BIW-1:0]         w_head_bank;
  logic [ROW_BITS-1:0]    w_head_row;
  cmd_e                   w_cmd;
  logic [IW-1:0]          w_sel_idx;
  logic                   w_deq;
  logic                   w_enq;
  logic [IW-1:0]          w_wr_idx;
  logic [PADDR_BITS-1:0]  w_sel_addr;

  // Bank group sits directly above bank, so {bg,bank} is the flat bank index.
  function automatic logic [BIW-1:0] f_bank(input logic [PADDR_BITS-1:0] a);
    return a[OFF+COL_BITS +: BIW];
  endfunction

  function automatic logic [ROW_BITS-1:0] f_row(input logic [PADDR_BITS-1:0] a);
    return a[PADDR_BITS-1 -: ROW_BITS];
  endfunction

  // Scan downward so the oldest qualifying entry wins.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = SCAN - 1; i >= 0; i--) begin
      if ((CW'(i) < r_count) && !bursting && r_open[f_bank(r_q_addr[i])] &&
          (r_row[f_bank(r_q_addr[i])] == f_row(r_q_addr[i])) &&
          (r_tmr[f_bank(r_q_addr[i])] == '0)) begin
        w_hit     = 1'b1;
        w_hit_idx = IW'(i);
      end
    end
  end

  assign w_head_bank = f_bank(r_q_addr[0]);
  assign w_head_row  = f_row(r_q_addr[0]);

  always_comb begin
    w_cmd     = CMD_NOP;
    w_sel_idx = '0;
    if (cmd_ready && (r_count != '0)) begin
      if (w_hit) begin
        w_cmd     = r_q_wr[w_hit_idx] ? CMD_WR : CMD_RD;
        w_sel_idx = w_hit_idx;
      end else if (r_tmr[w_head_bank] == '0) begin
        if (!r_open[w_head_bank])
          w_cmd = CMD_ACT;
        else if (r_row[w_head_bank] != w_head_row)
          w_cmd = CMD_PRE;
      end
    end
  end

  assign w_deq      = (w_cmd == CMD_RD) || (w_cmd == CMD_WR);
  assign w_enq      = valid_in && (r_count != CW'(QUEUE_SIZE));
  assign w_wr_idx   = IW'(r_count - CW'(w_deq));
  assign w_sel_addr = r_q_addr[w_sel_idx];

  always_ff @(posedge clk_in) begin
    if (rst_in)
      r_count <= '0;
    else
      r_count <= r_count + CW'(w_enq) - CW'(w_deq);
  end

  // Payload needs no reset: r_count alone defines which slots are live.
  always_ff @(posedge clk_in) begin
    for (int i = 0; i < QUEUE_SIZE - 1; i++) begin
      if (w_deq && (IW'(i) >= w_sel_idx)) begin
        r_q_addr[i] <= r_q_addr[i+1];
        r_q_wr[i]   <= r_q_wr[i+1];
        r_q_val[i]  <= r_q_val[i+1];
      end
    end
    if (w_enq) begin
      r_q_addr[w_wr_idx] <= mem_bus_addr_in;
      r_q_wr[w_wr_idx]   <= write_in;
      r_q_val[w_wr_idx]  <= val_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int b = 0; b < BANKS; b++) begin
        r_open[b] <= 1'b0;
        r_row[b]  <= '0;
        r_tmr[b]  <= '0;
      end
    end else begin
      for (int b = 0; b < BANKS; b++) begin
        if (r_tmr[b] != '0)
          r_tmr[b] <= r_tmr[b] - TW'(1);
      end
      if (w_cmd == CMD_ACT) begin
        r_open[w_head_bank] <= 1'b1;
        r_row[w_head_bank]  <= w_head_row;
        r_tmr[w_head_bank]  <= TW'(ACTIVATION_LATENCY);
      end else if (w_cmd == CMD_PRE) begin
        r_open[w_head_bank] <= 1'b0;
        r_tmr[w_head_bank]  <= TW'(PRECHARGE_LATENCY);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in || (w_cmd == CMD_NOP)) begin
      r_addr_out  <= '0;
      r_bg_out    <= '0;
      r_bank_out  <= '0;
      r_row_out   <= '0;
      r_col_out   <= '0;
      r_val_out   <= '0;
      r_cmd_out   <= CMD_NOP;
      r_valid_out <= 1'b0;
    end else begin
      r_addr_out  <= w_sel_addr;
      r_bg_out    <= w_sel_addr[OFF+COL_BITS+BKW +: BGW];
      r_bank_out  <= w_sel_addr[OFF+COL_BITS +: BKW];
      r_row_out   <= f_row(w_sel_addr);
      r_col_out   <= w_sel_addr[OFF +: COL_BITS];
      r_val_out   <= (w_cmd == CMD_WR) ? r_q_val[w_sel_idx] : '0;
      r_cmd_out   <= w_cmd;
      r_valid_out <= 1'b1;
    end
  end

  assign addr_out       = r_addr_out;
  assign bank_group_out = r_bg_out;
  assign bank_out       = r_bank_out;
  assign row_out        = r_row_out;
  assign col_out        = r_col_out;
  assign val_out        = r_val_out;
  assign cmd_out        = r_cmd_out;
  assign valid_out      = r_valid_out;

endmodule

// File: tb/tb_request_scheduler.sv
// tb_request_scheduler: directed and random stimulus against a queue/timestamp reference model.
module tb_request_scheduler;

  localparam int ACT_LAT = 8;
  localparam int PRE_LAT = 5;
  localparam int QS      = 16;
`ifdef SCHED_FRFCFS_EN
  localparam bit FRFCFS = 1'b1;
`else
  localparam bit FRFCFS = 1'b0;
`endif

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic [18:0]   mem_bus_addr_in = '0;
  logic          valid_in = 1'b0;
  logic          write_in = 1'b0;
  logic [511:0]  val_in = '0;
  logic          cmd_ready = 1'b0;
  logic          bursting = 1'b0;
  logic [18:0]   addr_out;
  logic          bank_group_out;
  logic [1:0]    bank_out;
  logic [7:0]    row_out;
  logic [3:0]    col_out;
  logic [511:0]  val_out;
  logic [2:0]    cmd_out;
  logic          valid_out;

  always #5 clk_in = ~clk_in;

  request_scheduler dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .mem_bus_addr_in (mem_bus_addr_in),
    .valid_in        (valid_in),
    .write_in        (write_in),
    .val_in          (val_in),
    .cmd_ready       (cmd_ready),
    .bursting        (bursting),
    .addr_out        (addr_out),
    .bank_group_out  (bank_group_out),
    .bank_out        (bank_out),
    .row_out         (row_out),
    .col_out         (col_out),
    .val_out         (val_out),
    .cmd_out         (cmd_out),
    .valid_out       (valid_out)
  );

  typedef struct { logic [18:0] a; logic w; logic [511:0] v; } req_t;
  typedef struct { logic [2:0] c; int bk; logic [7:0] row; logic [3:0] col; logic [511:0] v; longint t; } ev_t;

  req_t        mq[$];
  ev_t         lg[$];
  bit          m_open [8];
  logic [7:0]  m_row  [8];
  longint      m_rdy  [8];
  longint      t_now = 0;
  int          n_pass = 0;
  int          n_tot  = 0;
  int          n_fail = 0;

  function automatic logic [18:0] mk(input int bg, input int bk, input logic [7:0] row, input logic [3:0] col);
    logic [0:0] g;
    logic [1:0] k;
    g = bg[0:0];
    k = bk[1:0];
    return {row, g, k, col, 4'h0};
  endfunction

  function automatic int bk_of(input logic [18:0] a);
    return int'(a[10:8]);
  endfunction

  function automatic int cnt(input logic [2:0] c);
    int n = 0;
    foreach (lg[i]) if (lg[i].c == c) n++;
    return n;
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, predict from model, sample 1ns after posedge, then advance the model.
  task automatic cyc(input bit r, input bit v, input logic [18:0] a, input bit w,
                     input logic [511:0] d, input bit rdy, input bit bst);
    logic [2:0] e_cmd;
    int         e_idx;
    int         lim;
    int         b;
    bit         found;
    int         pre_size;
    req_t       e_req;
    @(negedge clk_in);
    rst_in = r; valid_in = v; mem_bus_addr_in = a; write_in = w; val_in = d;
    cmd_ready = rdy; bursting = bst;
    e_cmd = 3'd0; e_idx = 0; found = 1'b0;
    if (!r && rdy && mq.size() > 0) begin
      lim = FRFCFS ? mq.size() : 1;
      for (int i = 0; i < lim && !found; i++) begin
        b = bk_of(mq[i].a);
        if (!bst && m_open[b] && m_row[b] == mq[i].a[18:11] && t_now >= m_rdy[b]) begin
          found = 1'b1;
          e_idx = i;
        end
      end
      if (found) e_cmd = mq[e_idx].w ? 3'd3 : 3'd2;
      else begin
        b = bk_of(mq[0].a);
        if (t_now >= m_rdy[b]) begin
          if (!m_open[b]) e_cmd = 3'd1;
          else if (m_row[b] != mq[0].a[18:11]) e_cmd = 3'd4;
        end
      end
    end
    @(posedge clk_in);
    #1;
    chk("cmd", {valid_out, cmd_out}, {e_cmd != 3'd0, e_cmd});
    if (e_cmd != 3'd0) begin
      e_req = mq[e_idx];
      chk("fields", {addr_out, bank_group_out, bank_out, row_out, col_out},
          {e_req.a, e_req.a[10], e_req.a[9:8], e_req.a[18:11], e_req.a[7:4]});
      chk("val", val_out, (e_cmd == 3'd3) ? e_req.v : 512'd0);
    end
    if (valid_out)
      lg.push_back('{c: cmd_out, bk: int'({bank_group_out, bank_out}), row: row_out,
                     col: col_out, v: val_out, t: t_now});
    if (r) begin
      mq.delete();
      for (int i = 0; i < 8; i++) begin m_open[i] = 1'b0; m_row[i] = '0; m_rdy[i] = 0; end
    end else begin
      pre_size = mq.size();
      // A bank's counter loaded at edge t reaches zero just before edge t+LAT+1.
      case (e_cmd)
        3'd1: begin
          b = bk_of(mq[0].a);
          m_open[b] = 1'b1; m_row[b] = mq[0].a[18:11]; m_rdy[b] = t_now + ACT_LAT + 1;
        end
        3'd4: begin
          b = bk_of(mq[0].a);
          m_open[b] = 1'b0; m_rdy[b] = t_now + PRE_LAT + 1;
        end
        3'd2, 3'd3: mq.delete(e_idx);
        default: ;
      endcase
      if (v && pre_size < QS) mq.push_back('{a: a, w: w, v: d});
    end
    t_now++;
  endtask

  task automatic idle(input int n, input bit rdy, input bit bst);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, 1'b0, '0, rdy, bst);
  endtask

  task automatic req(input logic [18:0] a, input bit w, input logic [511:0] d, input bit rdy, input bit bst);
    cyc(1'b0, 1'b1, a, w, d, rdy, bst);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin m_open[i] = 1'b0; m_row[i] = '0; m_rdy[i] = 0; end

    cyc(1'b1, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    chk("reset_outputs", {valid_out, cmd_out, addr_out, row_out, col_out, val_out}, '0);

    // Write to bg1 bank1 row 0x55 col 0xA
    lg.delete();
    req(19'h2ADA0, 1'b1, 512'hA5A5A5A5A5A5A5A5, 1'b1, 1'b0);
    idle(12, 1'b1, 1'b0);
    chk("t1_count", lg.size(), 2);
    if (lg.size() >= 2) begin
      chk("t1_act", {lg[0].c, lg[0].bk[2:0], lg[0].row}, {3'd1, 3'd5, 8'h55});
      chk("t1_wr", {lg[1].c, lg[1].col}, {3'd3, 4'hA});
      chk("t1_val", lg[1].v, 512'hA5A5A5A5A5A5A5A5);
      chk("t1_gap", (lg[1].t - lg[0].t) >= ACT_LAT, 1);
    end

    // Two reads to the same row: one ACT, then both reads in order
    lg.delete();
    req(mk(0, 1, 8'hF0, 4'h6), 1'b0, '0, 1'b1, 1'b0);
    req(mk(0, 1, 8'hF0, 4'h1), 1'b0, '0, 1'b1, 1'b0);
    idle(14, 1'b1, 1'b0);
    chk("t2_count", lg.size(), 3);
    chk("t2_no_pre", cnt(3'd4), 0);
    if (lg.size() >= 3)
      chk("t2_seq", {lg[0].c, lg[1].c, lg[1].col, lg[2].c, lg[2].col},
          {3'd1, 3'd2, 4'h6, 3'd2, 4'h1});

    // Row conflict: PRE, ACT new row, READ
    lg.delete();
    req(mk(0, 1, 8'h0F, 4'h8), 1'b0, '0, 1'b1, 1'b0);
    idle(22, 1'b1, 1'b0);
    chk("t3_count", lg.size(), 3);
    if (lg.size() >= 3) begin
      chk("t3_seq", {lg[0].c, lg[1].c, lg[1].row, lg[2].c, lg[2].col},
          {3'd4, 3'd1, 8'h0F, 3'd2, 4'h8});
      chk("t3_pre_gap", (lg[1].t - lg[0].t) >= PRE_LAT, 1);
      chk("t3_act_gap", (lg[2].t - lg[1].t) >= ACT_LAT, 1);
    end

    // cmd_ready low blocks everything
    lg.delete();
    req(mk(0, 2, 8'h33, 4'h2), 1'b0, '0, 1'b0, 1'b0);
    idle(10, 1'b0, 1'b0);
    chk("t4_hold", lg.size(), 0);
    idle(12, 1'b1, 1'b0);
    chk("t4_release", cnt(3'd2), 1);

    // bursting blocks READ/WRITE but not PRE/ACT
    lg.delete();
    req(mk(0, 2, 8'h44, 4'h5), 1'b0, '0, 1'b1, 1'b1);
    idle(25, 1'b1, 1'b1);
    chk("t5_count", lg.size(), 2);
    if (lg.size() >= 2) chk("t5_seq", {lg[0].c, lg[1].c}, {3'd4, 3'd1});
    idle(3, 1'b1, 1'b0);
    chk("t5_read", cnt(3'd2), 1);

    // 17 requests while stalled: the 17th is dropped
    lg.delete();
    for (int i = 0; i < 17; i++)
      req(mk(1, 0, 8'h20, i[3:0]), i[0], {$urandom, $urandom}, 1'b0, 1'b0);
    idle(40, 1'b1, 1'b0);
    chk("t6_rw", cnt(3'd2) + cnt(3'd3), 16);

    // Reset mid-sequence discards pending work
    req(mk(0, 3, 8'h07, 4'h1), 1'b0, '0, 1'b1, 1'b0);
    req(mk(0, 3, 8'h07, 4'h2), 1'b1, 512'h1234, 1'b1, 1'b0);
    req(mk(0, 3, 8'h08, 4'h3), 1'b0, '0, 1'b1, 1'b0);
    idle(2, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    chk("t7_rst_out", {valid_out, cmd_out, addr_out, row_out, col_out, val_out}, '0);
    lg.delete();
    idle(20, 1'b1, 1'b0);
    chk("t7_quiet", lg.size(), 0);

    // Random traffic against the model
    for (int i = 0; i < 800; i++) begin
      logic [18:0] ra;
      ra = mk($urandom_range(0, 1), $urandom_range(0, 3), 8'h10 + 8'($urandom_range(0, 1)),
              4'($urandom_range(0, 15)));
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 9) < 4, ra, $urandom_range(0, 1),
          {$urandom, $urandom}, $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 2);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
